clock_button_controller: RTL and testbench

Front-end stage for the hour/minute/second time-setting counter. It synchronises and debounces three raw push-buttons (mode, up, down) and runs a mode FSM: RUN → SET_HOUR → SET_MINUTE → SET_SECOND → RUN. It drives the counter's one-hot mode_hour/mode_minute/mode_second levels and its single-cycle up/down pulses, with auto-repeat on hold and an inactivity timeout back to RUN.

---
 rtl/clock_button_controller_if.sv | 31 +++
 rtl/clock_button_controller.sv | 199 +++++++++++++++++++
 tb/tb_clock_button_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_button_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_button_if
// Brief    : Raw push-button inputs and time-setting controls exchanged
//            between the button front end and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_button_if;
    logic btn_mode;
    logic btn_up;
    logic btn_down;
    logic mode_hour;
    logic mode_minute;
    logic mode_second;
    logic up;
    logic down;
    logic setting;

    // Environment side: drives the buttons, observes the counter controls
    modport master (
        output btn_mode, btn_up, btn_down,
        input  mode_hour, mode_minute, mode_second, up, down, setting
    );

    // Controller side
    modport slave (
        input  btn_mode, btn_up, btn_down,
        output mode_hour, mode_minute, mode_second, up, down, setting
    );
endinterface
`default_nettype wire

// File: rtl/clock_button_controller.sv
`default_nettype none
// ============================================================================
// Module   : clock_button_controller
// Brief    : Synchronises and debounces mode/up/down buttons, runs the
//            RUN -> SET_HOUR -> SET_MINUTE -> SET_SECOND mode FSM and
//            produces single-cycle up/down pulses with hold auto-repeat
//            and an inactivity timeout back to RUN.
// Revision : 1.0 - initial release
// ============================================================================
module clock_button_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    clock_button_if.slave bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0]  c_db_last     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] c_delay_last  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] c_period_last = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [TO_W-1:0]  c_to_last     = TO_W'(TIMEOUT_CYCLES - 1);

    // Button index: 0 = mode, 1 = up, 2 = down
    logic [2:0] w_raw;
    logic [2:0] w_lvl;
    logic [2:0] w_press;
    logic [1:0] r_fill;

    assign w_raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

    // Marks when the synchroniser outputs reflect post-reset samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fill <= 2'b00;
        else        r_fill <= {r_fill[0], 1'b1};
    end

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic            r_s1;
        logic            r_s2;
        logic            r_lvl;
        logic            r_lvl_d;
        logic            r_arm;
        logic [DB_W-1:0] r_cnt;

        // Two-flop synchroniser, debounce counter and press-edge history.
        // A button only arms once it has been seen released, so one held
        // through reset cannot produce a press on its first settle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_lvl   <= 1'b0;
                r_lvl_d <= 1'b0;
                r_arm   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_raw[i];
                r_s2    <= r_s1;
                r_lvl_d <= r_lvl;
                if (r_s2 != r_lvl) begin
                    if (r_cnt == c_db_last) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
                if (r_fill[1] && !r_s2) r_arm <= 1'b1;
            end
        end

        assign w_lvl[i]   = r_lvl;
        assign w_press[i] = r_lvl & ~r_lvl_d & r_arm;
    end

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOUR   = 2'd1,
        ST_MINUTE = 2'd2,
        ST_SECOND = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_setting;
    logic             w_any_held;
    logic             w_timeout;
    logic             w_change;
    logic             r_mode_hour;
    logic             r_mode_minute;
    logic             r_mode_second;
    logic             r_up;
    logic             r_down;
    logic             r_rep_active;
    logic             r_rep_dn;
    logic             r_rep_first;
    logic [REP_W-1:0] r_rep_cnt;
    logic [TO_W-1:0]  r_idle;

    assign w_setting  = (r_state != ST_RUN);
    assign w_any_held = |w_lvl;
    assign w_timeout  = w_setting && !w_any_held && (r_idle == c_to_last);
    assign w_change   = w_press[0] || w_timeout;

    // Next mode: a mode press advances the ring, timeout forces RUN
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = ST_RUN;
        end else if (w_press[0]) begin
            case (r_state)
                ST_RUN:    w_state_nxt = ST_HOUR;
                ST_HOUR:   w_state_nxt = ST_MINUTE;
                ST_MINUTE: w_state_nxt = ST_SECOND;
                default:   w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Mode FSM, registered mode levels, pulse/auto-repeat and inactivity timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_mode_hour   <= 1'b0;
            r_mode_minute <= 1'b0;
            r_mode_second <= 1'b0;
            r_up          <= 1'b0;
            r_down        <= 1'b0;
            r_rep_active  <= 1'b0;
            r_rep_dn      <= 1'b0;
            r_rep_first   <= 1'b0;
            r_rep_cnt     <= '0;
            r_idle        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_mode_hour   <= (w_state_nxt == ST_HOUR);
            r_mode_minute <= (w_state_nxt == ST_MINUTE);
            r_mode_second <= (w_state_nxt == ST_SECOND);
            r_up          <= 1'b0;
            r_down        <= 1'b0;

            if (w_change || !w_setting) begin
                // Transitions and RUN both discard any repeat in progress
                r_rep_active <= 1'b0;
                r_rep_first  <= 1'b0;
                r_rep_cnt    <= '0;
                r_idle       <= '0;
            end else begin
                r_idle <= w_any_held ? '0 : r_idle + 1'b1;

                if (w_lvl[1] && w_lvl[2]) begin
                    // Conflicting hold: silence, and require a fresh press
                    r_rep_active <= 1'b0;
                    r_rep_first  <= 1'b0;
                    r_rep_cnt    <= '0;
                end else if (w_press[1] || w_press[2]) begin
                    r_up         <= w_press[1];
                    r_down       <= w_press[2];
                    r_rep_active <= 1'b1;
                    r_rep_dn     <= w_press[2];
                    r_rep_first  <= 1'b1;
                    r_rep_cnt    <= '0;
                end else if (r_rep_active && (r_rep_dn ? w_lvl[2] : w_lvl[1])) begin
                    if (r_rep_cnt == (r_rep_first ? c_delay_last : c_period_last)) begin
                        r_up        <= !r_rep_dn;
                        r_down      <= r_rep_dn;
                        r_rep_first <= 1'b0;
                        r_rep_cnt   <= '0;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
                end else begin
                    r_rep_active <= 1'b0;
                    r_rep_first  <= 1'b0;
                    r_rep_cnt    <= '0;
                end
            end
        end
    end

    assign bus.mode_hour   = r_mode_hour;
    assign bus.mode_minute = r_mode_minute;
    assign bus.mode_second = r_mode_second;
    assign bus.up          = r_up;
    assign bus.down        = r_down;
    assign bus.setting     = r_mode_hour | r_mode_minute | r_mode_second;

endmodule
`default_nettype wire

// File: tb/tb_clock_button_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_button_controller
// Brief    : Directed self-checking bench for clock_button_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_button_controller;

    logic clk;
    logic rst_n;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   up_cnt = 0;
    int   dn_cnt = 0;
    int   both_cnt = 0;
    int   up_times[$];

    clock_button_if bus ();

    clock_button_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value seen at negedge is the index of the last rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled away from the active edge
    always @(negedge clk) begin
        if (bus.up) begin
            up_cnt++;
            up_times.push_back(cyc);
        end
        if (bus.down) dn_cnt++;
        if (bus.up && bus.down) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       bus.btn_mode = v;
            1:       bus.btn_up   = v;
            default: bus.btn_down = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        tick(hold);
        set_btn(b, 1'b0);
        tick(12);
    endtask

    function automatic logic [2:0] modes();
        return {bus.mode_hour, bus.mode_minute, bus.mode_second};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded bound", $time);
        $fatal(1);
    end

    initial begin
        int c0;
        int base;
        int u0;
        int d0;

        rst_n        = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        tick(3);
        chk("reset_outputs", {modes(), bus.up, bus.down, bus.setting}, 6'b0);
        rst_n = 1'b1;
        tick(5);

        // 1: mode ring and press latency
        bus.btn_mode = 1'b1;
        tick(6);
        chk("t1_hour_edge6", bus.mode_hour, 1'b0);
        tick(1);
        chk("t1_hour_edge7", bus.mode_hour, 1'b1);
        chk("t1_setting", bus.setting, 1'b1);
        tick(1);
        bus.btn_mode = 1'b0;
        tick(12);
        press(0, 8);
        chk("t1_minute", modes(), 3'b010);
        press(0, 8);
        chk("t1_second", modes(), 3'b001);
        press(0, 8);
        chk("t1_run", {modes(), bus.setting}, 4'b0);

        // 2: glitch rejection in SET_HOUR
        press(0, 8);
        chk("t2_hour", modes(), 3'b100);
        u0 = up_cnt;
        for (int g = 1; g <= 3; g++) begin
            bus.btn_up = 1'b1;
            tick(g);
            bus.btn_up = 1'b0;
            tick(6);
        end
        chk("t2_glitch_no_up", up_cnt - u0, 0);
        press(1, 8);
        chk("t2_hold_one_up", up_cnt - u0, 1);

        // 3: auto-repeat in SET_MINUTE
        press(0, 8);
        chk("t3_minute", modes(), 3'b010);
        u0   = up_cnt;
        d0   = dn_cnt;
        base = up_times.size();
        c0   = cyc;
        bus.btn_up = 1'b1;
        tick(40);
        bus.btn_up = 1'b0;
        tick(12);
        chk("t3_up_count", up_cnt - u0, 7);
        chk("t3_first_P", up_times[base] - c0, 7);
        chk("t3_repeat1", up_times[base + 1] - c0, 23);
        chk("t3_repeat2", up_times[base + 2] - c0, 27);
        chk("t3_last", up_times[up_times.size() - 1] - c0, 43);
        chk("t3_no_down", dn_cnt - d0, 0);

        // 4: conflicting hold in SET_HOUR, then up in RUN
        press(0, 8);
        press(0, 8);
        press(0, 8);
        chk("t4_hour", modes(), 3'b100);
        u0 = up_cnt;
        d0 = dn_cnt;
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        tick(30);
        bus.btn_down = 1'b0;
        tick(30);
        bus.btn_up = 1'b0;
        tick(12);
        chk("t4_both_no_up", up_cnt - u0, 0);
        chk("t4_both_no_down", dn_cnt - d0, 0);
        press(2, 8);
        chk("t4_down_alone", dn_cnt - d0, 1);
        press(0, 8);
        press(0, 8);
        press(0, 8);
        chk("t4_run", modes(), 3'b000);
        u0 = up_cnt;
        press(1, 30);
        chk("t4_run_no_up", up_cnt - u0, 0);

        // 5: inactivity timeout from SET_SECOND
        press(0, 8);
        press(0, 8);
        press(0, 8);
        chk("t5_second", modes(), 3'b001);
        bus.btn_down = 1'b1;
        tick(300);
        chk("t5_held_no_timeout", bus.setting, 1'b1);
        bus.btn_down = 1'b0;
        tick(250);
        chk("t5_before_timeout", bus.setting, 1'b1);
        tick(20);
        chk("t5_after_timeout", {modes(), bus.setting}, 4'b0);

        // 6: asynchronous reset mid-repeat, button held through release
        press(0, 8);
        chk("t6_hour", modes(), 3'b100);
        u0 = up_cnt;
        bus.btn_up = 1'b1;
        tick(30);
        chk("t6_pulses_before_rst", up_cnt - u0, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {modes(), bus.up, bus.down, bus.setting}, 6'b0);
        tick(3);
        rst_n = 1'b1;
        u0 = up_cnt;
        tick(40);
        chk("t6_held_no_up", up_cnt - u0, 0);
        chk("t6_still_run", bus.setting, 1'b0);
        bus.btn_up = 1'b0;
        tick(12);
        press(0, 8);
        chk("t6_rearm_hour", modes(), 3'b100);
        u0 = up_cnt;
        press(1, 8);
        chk("t6_repress_up", up_cnt - u0, 1);

        chk("never_up_and_down", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
